// File: rtl/bsr_mem_resp_if.sv
// EX-stage memory port: request from EX (master), response from the memory responder (slave).
interface bsr_mem_resp_if;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [4:0]  memOpm;
  logic [31:0] memDataLd;
  logic [1:0]  memDataOK;

  modport master (
    output memAddr, memData, memOpm,
    input  memDataLd, memDataOK
  );

  modport slave (
    input  memAddr, memData, memOpm,
    output memDataLd, memDataOK
  );
endinterface

// File: rtl/bsr_mem_resp.sv
// Memory-side responder: decodes EX requests onto a little-endian 32-bit data RAM,
// splitting misaligned word/long accesses into two RAM cycles.
module bsr_mem_resp #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000C000
) (
  input logic           clock,
  input logic           reset,
  bsr_mem_resp_if.slave mem
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR2, S_RESP, S_FLT} state_e;

  localparam logic [1:0] OK_READY = 2'b00;
  localparam logic [1:0] OK_OK    = 2'b01;
  localparam logic [1:0] OK_HOLD  = 2'b10;
  localparam logic [1:0] OK_FAULT = 2'b11;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_RD    = 2'b01;
  localparam logic [1:0] OP_WR    = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] SZ_B     = 2'b00;
  localparam logic [1:0] SZ_W     = 2'b01;
  localparam logic [1:0] SZ_RSVD  = 2'b11;

  state_e state_q, state_d;

  // Request fields as presented by EX
  logic [1:0]        req_op;
  logic [1:0]        req_size;
  logic              req_uns;
  logic [1:0]        req_lane;
  logic [ADDR_W-1:0] req_idx;
  logic              req_hit;
  logic              req_split;
  logic              req_fault;
  logic              req_accept;
  logic [31:0]       req_data;
  logic [3:0]        req_be;
  logic [63:0]       st_data64;
  logic [7:0]        st_be8;

  // Request latched at IDLE acceptance
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              split_q;
  logic [31:0]       hi_data_q;
  logic [3:0]        hi_be_q;
  logic [31:0]       lo_q;
  logic [31:0]       result_q;

  // RAM port
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata_q;
  logic [31:0]       mem_q [DEPTH];

  assign req_op    = mem.memOpm[4:3];
  assign req_uns   = mem.memOpm[2];
  assign req_size  = mem.memOpm[1:0];
  assign req_lane  = mem.memAddr[1:0];
  assign req_idx   = mem.memAddr[ADDR_W+1:2];
  assign req_hit   = (mem.memAddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign req_split = ((req_size == SZ_W) && (req_lane == 2'd3)) ||
                     ((req_size == 2'b10) && (req_lane != 2'd0));
  // A split that would need a word beyond the top index faults rather than wrapping.
  assign req_fault = !req_hit || (req_op == OP_RSVD) || (req_size == SZ_RSVD) ||
                     (req_split && (req_idx == {ADDR_W{1'b1}}));
  assign req_accept = (state_q == S_IDLE) && (req_op != OP_NONE);

  // Store data right-justified by size, then shifted into byte lanes across two words
  always_comb begin
    req_data = mem.memData;
    req_be   = 4'b1111;
    case (req_size)
      SZ_B: begin
        req_data = {24'b0, mem.memData[7:0]};
        req_be   = 4'b0001;
      end
      SZ_W: begin
        req_data = {16'b0, mem.memData[15:0]};
        req_be   = 4'b0011;
      end
      default: ;
    endcase
    st_data64 = {32'b0, req_data} << {req_lane, 3'b000};
    st_be8    = {4'b0, req_be} << req_lane;
  end

  // Extract the addressed bytes from a two-word window and extend to 32 bits
  function automatic logic [31:0] fmt_load(input logic [63:0] win, input logic [1:0] lane,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] w;
    w = 32'(win >> {lane, 3'b000});
    case (size)
      SZ_B:    fmt_load = uns ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      SZ_W:    fmt_load = uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: fmt_load = w;
    endcase
  endfunction

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_op != OP_NONE) begin
          if (req_fault)            state_d = S_FLT;
          else if (req_op == OP_RD) state_d = S_RD1;
          else if (req_split)       state_d = S_WR2;
          else                      state_d = S_RESP;
        end
      end
      S_RD1:   state_d = split_q ? S_RD2 : S_RESP;
      S_RD2:   state_d = S_RESP;
      S_WR2:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_FLT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs to EX; reset forces READY even if EX is still presenting a request
  always_comb begin
    mem.memDataOK = OK_READY;
    mem.memDataLd = '0;
    if (reset) begin
      case (state_q)
        S_IDLE:                mem.memDataOK = (req_op != OP_NONE) ? OK_HOLD : OK_READY;
        S_RD1, S_RD2, S_WR2:   mem.memDataOK = OK_HOLD;
        S_RESP: begin
          mem.memDataOK = OK_OK;
          mem.memDataLd = result_q;
        end
        S_FLT:                 mem.memDataOK = OK_FAULT;
        default:               mem.memDataOK = OK_READY;
      endcase
    end
  end

  // RAM port control: first word in IDLE, second word in RD1 (split read) or WR2
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = idx_q;
    ram_be    = 4'b0000;
    ram_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if ((req_op != OP_NONE) && !req_fault) begin
          ram_en    = 1'b1;
          ram_addr  = req_idx;
          ram_we    = (req_op == OP_WR);
          ram_be    = st_be8[3:0];
          ram_wdata = st_data64[31:0];
        end
      end
      S_RD1: begin
        ram_en   = split_q;
        ram_addr = idx_q + ADDR_W'(1);
      end
      S_WR2: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = idx_q + ADDR_W'(1);
        ram_be    = hi_be_q;
        ram_wdata = hi_data_q;
      end
      default: ;
    endcase
  end

  // Request capture and load result assembly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q     <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      split_q   <= 1'b0;
      hi_data_q <= '0;
      hi_be_q   <= '0;
      lo_q      <= '0;
      result_q  <= '0;
    end else begin
      if (req_accept) begin
        idx_q     <= req_idx;
        lane_q    <= req_lane;
        size_q    <= req_size;
        uns_q     <= req_uns;
        split_q   <= req_split;
        hi_data_q <= st_data64[63:32];
        hi_be_q   <= st_be8[7:4];
        result_q  <= '0;
      end
      if (state_q == S_RD1) begin
        lo_q <= ram_rdata_q;
        if (!split_q) result_q <= fmt_load({32'b0, ram_rdata_q}, lane_q, size_q, uns_q);
      end
      if (state_q == S_RD2) begin
        result_q <= fmt_load({ram_rdata_q, lo_q}, lane_q, size_q, uns_q);
      end
    end
  end

  // Byte-enabled RAM, 1-cycle synchronous read, written bytes returned on read (write-first)
  // NOTE: the RAM array has no reset so it maps onto block memory; contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_we && ram_be[i]) begin
          mem_q[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
          ram_rdata_q[8*i +: 8]     <= ram_wdata[8*i +: 8];
        end else begin
          ram_rdata_q[8*i +: 8]     <= mem_q[ram_addr][8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_bsr_mem_resp.sv
// Directed bench for bsr_mem_resp: handshake latency, load extension, byte-lane stores,
// split accesses, faults, async reset mid-transaction and back-to-back requests.
module tb_bsr_mem_resp;

  localparam logic [1:0] OK_READY = 2'b00;
  localparam logic [1:0] OK_OK    = 2'b01;
  localparam logic [1:0] OK_HOLD  = 2'b10;
  localparam logic [1:0] OK_FAULT = 2'b11;
  localparam logic [1:0] RD = 2'b01, WR = 2'b10, RSV = 2'b11;
  localparam logic [1:0] SZ_B = 2'b00, SZ_W = 2'b01, SZ_L = 2'b10, SZ_X = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bsr_mem_resp_if bus ();

  bsr_mem_resp #(.ADDR_W(12), .BASE_ADDR(32'h0000C000)) dut (
    .clock (clk),
    .reset (rst_n),
    .mem   (bus)
  );

  function automatic logic [4:0] opm(input logic [1:0] op, input logic uns, input logic [1:0] sz);
    return {op, uns, sz};
  endfunction

  // Present a request at a negedge while the DUT is idle; count HOLD samples until OK/FAULT.
  // A response that never arrives leaves ok at READY, which the caller's check reports.
  task automatic run_req(input logic [4:0] o, input logic [31:0] a, input logic [31:0] d,
                         output int holds, output logic [1:0] ok, output logic [31:0] ld);
    holds = 0;
    ok    = OK_READY;
    ld    = 32'hDEAD_0000;
    bus.memOpm  = o;
    bus.memAddr = a;
    bus.memData = d;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (bus.memDataOK === OK_HOLD) begin
        holds++;
        @(negedge clk);
      end else begin
        ok = bus.memDataOK;
        ld = bus.memDataLd;
        break;
      end
    end
    bus.memOpm = 5'b0;
    @(negedge clk);
  endtask

  int          h;
  logic [1:0]  k;
  logic [31:0] v;

  task automatic test_reset();
    bus.memOpm  = opm(RD, 1'b0, SZ_L);
    bus.memAddr = 32'h0000C000;
    bus.memData = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.memDataOK !== OK_READY) $display("FAIL rst_ok got %b want %b", bus.memDataOK, OK_READY); else n_pass++;
    n_total++; if (bus.memDataLd !== 32'h0) $display("FAIL rst_ld got %h want 00000000", bus.memDataLd); else n_pass++;
    @(negedge clk);
    bus.memOpm = 5'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (bus.memDataOK !== OK_READY) $display("FAIL idle_ok got %b want %b", bus.memDataOK, OK_READY); else n_pass++;
  endtask

  task automatic test_aligned_long();
    run_req(opm(WR, 1'b0, SZ_L), 32'h0000C000, 32'h11223344, h, k, v);
    n_total++; if (h !== 1) $display("FAIL wrL_holds got %0d want 1", h); else n_pass++;
    n_total++; if (k !== OK_OK) $display("FAIL wrL_ok got %b want %b", k, OK_OK); else n_pass++;
    n_total++; if (v !== 32'h0) $display("FAIL wrL_ld got %h want 00000000", v); else n_pass++;
    run_req(opm(RD, 1'b1, SZ_L), 32'h0000C000, 32'h0, h, k, v);
    n_total++; if (h !== 2) $display("FAIL rdL_holds got %0d want 2", h); else n_pass++;
    n_total++; if (k !== OK_OK) $display("FAIL rdL_ok got %b want %b", k, OK_OK); else n_pass++;
    n_total++; if (v !== 32'h11223344) $display("FAIL rdL_ld got %h want 11223344", v); else n_pass++;
  endtask

  task automatic test_byte_word();
    run_req(opm(RD, 1'b0, SZ_B), 32'h0000C003, 32'h0, h, k, v);
    n_total++; if (v !== 32'h00000011) $display("FAIL rdSB3 got %h want 00000011", v); else n_pass++;
    // Upper data bits must be ignored for a byte store
    run_req(opm(WR, 1'b0, SZ_B), 32'h0000C001, 32'hABCDEFF0, h, k, v);
    n_total++; if (k !== OK_OK || h !== 1) $display("FAIL wrB got ok=%b holds=%0d want 01/1", k, h); else n_pass++;
    run_req(opm(RD, 1'b0, SZ_B), 32'h0000C001, 32'h0, h, k, v);
    n_total++; if (v !== 32'hFFFFFFF0) $display("FAIL rdSB1 got %h want FFFFFFF0", v); else n_pass++;
    run_req(opm(RD, 1'b1, SZ_B), 32'h0000C001, 32'h0, h, k, v);
    n_total++; if (v !== 32'h000000F0) $display("FAIL rdUB1 got %h want 000000F0", v); else n_pass++;
    run_req(opm(RD, 1'b0, SZ_L), 32'h0000C000, 32'h0, h, k, v);
    n_total++; if (v !== 32'h1122F044) $display("FAIL rdL_after_B got %h want 1122F044", v); else n_pass++;
    run_req(opm(RD, 1'b0, SZ_W), 32'h0000C000, 32'h0, h, k, v);
    n_total++; if (v !== 32'hFFFFF044) $display("FAIL rdSW0 got %h want FFFFF044", v); else n_pass++;
    run_req(opm(RD, 1'b1, SZ_W), 32'h0000C000, 32'h0, h, k, v);
    n_total++; if (v !== 32'h0000F044) $display("FAIL rdUW0 got %h want 0000F044", v); else n_pass++;
    run_req(opm(RD, 1'b0, SZ_W), 32'h0000C002, 32'h0, h, k, v);
    n_total++; if (v !== 32'h00001122 || h !== 2) $display("FAIL rdSW2 got %h holds=%0d want 00001122/2", v, h); else n_pass++;
  endtask

  task automatic test_split();
    run_req(opm(WR, 1'b0, SZ_L), 32'h0000C004, 32'hAABBCCDD, h, k, v);
    n_total++; if (k !== OK_OK) $display("FAIL wrL4_ok got %b want %b", k, OK_OK); else n_pass++;
    run_req(opm(RD, 1'b0, SZ_L), 32'h0000C002, 32'h0, h, k, v);
    n_total++; if (h !== 3) $display("FAIL splitRd_holds got %0d want 3", h); else n_pass++;
    n_total++; if (k !== OK_OK || v !== 32'hCCDD1122) $display("FAIL splitRd got ok=%b ld=%h want 01/CCDD1122", k, v); else n_pass++;
    run_req(opm(WR, 1'b0, SZ_L), 32'h0000C003, 32'h01020304, h, k, v);
    n_total++; if (h !== 2 || k !== OK_OK) $display("FAIL splitWr got holds=%0d ok=%b want 2/01", h, k); else n_pass++;
    run_req(opm(RD, 1'b0, SZ_L), 32'h0000C000, 32'h0, h, k, v);
    n_total++; if (v !== 32'h0422F044) $display("FAIL splitWr_lo got %h want 0422F044", v); else n_pass++;
    run_req(opm(RD, 1'b0, SZ_L), 32'h0000C004, 32'h0, h, k, v);
    n_total++; if (v !== 32'hAA010203) $display("FAIL splitWr_hi got %h want AA010203", v); else n_pass++;
    run_req(opm(RD, 1'b1, SZ_W), 32'h0000C003, 32'h0, h, k, v);
    n_total++; if (v !== 32'h00000304 || h !== 3) $display("FAIL splitRdW got %h holds=%0d want 00000304/3", v, h); else n_pass++;
  endtask

  task automatic test_fault();
    run_req(opm(RD, 1'b0, SZ_L), 32'h00001000, 32'h0, h, k, v);
    n_total++; if (h !== 1 || k !== OK_FAULT) $display("FAIL miss got holds=%0d ok=%b want 1/11", h, k); else n_pass++;
    n_total++; if (v !== 32'h0) $display("FAIL miss_ld got %h want 00000000", v); else n_pass++;
    run_req(opm(WR, 1'b0, SZ_L), 32'h0000FFFC, 32'h55667788, h, k, v);
    n_total++; if (k !== OK_OK) $display("FAIL wrTop_ok got %b want %b", k, OK_OK); else n_pass++;
    run_req(opm(WR, 1'b0, SZ_L), 32'h0000FFFE, 32'hDEADBEEF, h, k, v);
    n_total++; if (k !== OK_FAULT) $display("FAIL topSplit got %b want %b", k, OK_FAULT); else n_pass++;
    run_req(opm(RD, 1'b0, SZ_L), 32'h0000FFFC, 32'h0, h, k, v);
    n_total++; if (v !== 32'h55667788) $display("FAIL topUnchanged got %h want 55667788", v); else n_pass++;
    run_req(opm(RSV, 1'b0, SZ_L), 32'h0000C000, 32'h0, h, k, v);
    n_total++; if (k !== OK_FAULT) $display("FAIL rsvOp got %b want %b", k, OK_FAULT); else n_pass++;
    run_req(opm(RD, 1'b0, SZ_X), 32'h0000C000, 32'h0, h, k, v);
    n_total++; if (k !== OK_FAULT) $display("FAIL rsvSize got %b want %b", k, OK_FAULT); else n_pass++;
  endtask

  task automatic test_reset_mid_split();
    bus.memOpm  = opm(RD, 1'b0, SZ_L);
    bus.memAddr = 32'h0000C002;
    bus.memData = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    n_total++; if (bus.memDataOK !== OK_HOLD) $display("FAIL rd2_hold got %b want %b", bus.memDataOK, OK_HOLD); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.memDataOK !== OK_READY || bus.memDataLd !== 32'h0) $display("FAIL midRst got ok=%b ld=%h want 00/00000000", bus.memDataOK, bus.memDataLd); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.memOpm = 5'b0;
    rst_n = 1'b1;
    @(negedge clk);
    // Words now hold C000=0422F044, C004=AA010203
    run_req(opm(RD, 1'b0, SZ_L), 32'h0000C002, 32'h0, h, k, v);
    n_total++; if (h !== 3 || k !== OK_OK || v !== 32'h02030422) $display("FAIL postRst got holds=%0d ok=%b ld=%h want 3/01/02030422", h, k, v); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  seq [5];
    logic [31:0] ld_a, ld_b;
    bus.memOpm  = opm(RD, 1'b1, SZ_L);
    bus.memAddr = 32'h0000C000;
    bus.memData = '0;
    #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.memDataOK !== OK_HOLD) break;
    end
    seq[0] = bus.memDataOK;
    ld_a   = bus.memDataLd;
    bus.memAddr = 32'h0000C004;
    ld_b = 32'hDEAD_0000;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      seq[i] = bus.memDataOK;
      if (i == 3) ld_b = bus.memDataLd;
    end
    bus.memOpm = 5'b0;
    @(negedge clk);
    seq[4] = bus.memDataOK;
    n_total++; if (seq[0] !== OK_OK || ld_a !== 32'h0422F044) $display("FAIL b2b_a got ok=%b ld=%h want 01/0422F044", seq[0], ld_a); else n_pass++;
    n_total++; if (seq[1] !== OK_HOLD || seq[2] !== OK_HOLD) $display("FAIL b2b_hold got %b,%b want 10,10", seq[1], seq[2]); else n_pass++;
    n_total++; if (seq[3] !== OK_OK || ld_b !== 32'hAA010203) $display("FAIL b2b_b got ok=%b ld=%h want 01/AA010203", seq[3], ld_b); else n_pass++;
    n_total++; if (seq[4] !== OK_READY) $display("FAIL b2b_end got %b want 00", seq[4]); else n_pass++;
  endtask

  initial begin
    bus.memOpm  = 5'b0;
    bus.memAddr = '0;
    bus.memData = '0;
    test_reset();
    test_aligned_long();
    test_byte_word();
    test_split();
    test_fault();
    test_reset_mid_split();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
